// File: rtl/vram_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its neighbours.
// It carries three groups of signals:
//   - VGA scan-out: read_pixel, row, col in; vga_data out.
//   - Pixel-write client: wr_valid, wr_x, wr_y, wr_color in; wr_ready out.
//   - Framebuffer RAM port: ram_addr, ram_we, ram_wdata out; ram_rdata in.
// The slave modport is the arbiter's view of the bus.
// The master modport is the view of the environment that drives it.
interface vram_arbiter_if;
  logic        read_pixel;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [11:0] vga_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [11:0] wr_color;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  modport slave (
    input  read_pixel, row, col,
    output vga_data,
    input  wr_valid, wr_x, wr_y, wr_color,
    output wr_ready,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output read_pixel, row, col,
    input  vga_data,
    output wr_valid, wr_x, wr_y, wr_color,
    input  wr_ready,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter.
// Display reads (read_pixel low) always own the RAM port.
// Non-display cycles go either to the whole-screen clear engine or to
// popping the small pixel-write FIFO.
// Ports:
//   clk_i        pixel clock
//   rst_ni       synchronous reset, active low
//   bus          vram_arbiter_if.slave (VGA, write client, RAM port)
//   clr_req_i    single-cycle clear request
//   clr_color_i  fill colour, sampled together with clr_req_i
//   clr_busy_o   high from clear acceptance until the last clear write
//   clr_done_o   one-cycle pulse after the last clear write
//
// state | meaning
// IDLE  | normal operation; FIFO accepts writes and pops on free slots
// DRAIN | clear accepted; emptying the FIFO before the fill starts
// CLEAR | writing the latched colour to every address, 0 upward
module vram_arbiter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vram_arbiter_if.slave bus,
  input  logic          clr_req_i,
  input  logic [11:0]   clr_color_i,
  output logic          clr_busy_o,
  output logic          clr_done_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] color;
  } entry_t;

  state_e        state_q;
  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [18:0]   clr_cnt_q, last_addr_q;
  logic [11:0]   clr_color_q, last_wdata_q;
  logic          clr_busy_q, clr_done_q;

  logic display, in_range, push, do_pop, do_clear;

  // Row-major address y*H_RES + x.
  // For H_RES = 640 the constant multiply reduces to (y<<9) + (y<<7).
  function automatic logic [18:0] pix_addr(input logic [8:0] y, input logic [9:0] x);
    return 19'(y) * 19'(H_RES) + 19'(x);
  endfunction

  assign display  = ~bus.read_pixel;
  assign in_range = (bus.wr_x < 10'(H_RES)) && (bus.wr_y < 9'(V_RES));

  // The ready signal uses the registered count.
  // A pop in the same cycle does not free a slot early.
  assign bus.wr_ready = (count_q < CW'(DEPTH)) && (state_q == IDLE);

  // Out-of-range writes complete the handshake but are dropped here.
  assign push = bus.wr_valid && bus.wr_ready && in_range;

  assign do_clear = rst_ni && !display && (state_q == CLEAR);
  assign do_pop   = rst_ni && !display && (state_q != CLEAR) && (count_q != '0);
  assign count_d  = count_q + CW'(push) - CW'(do_pop);

  assign bus.vga_data = bus.ram_rdata;
  assign clr_busy_o   = clr_busy_q;
  assign clr_done_o   = clr_done_q;

  // The RAM samples on the falling edge.
  // Address and data are therefore steered combinationally within the cycle.
  always_comb begin
    bus.ram_addr  = last_addr_q;
    bus.ram_wdata = last_wdata_q;
    bus.ram_we    = 1'b0;
    if (display) begin
      bus.ram_addr = pix_addr(bus.row, bus.col);
    end else if (do_clear) begin
      bus.ram_addr  = clr_cnt_q;
      bus.ram_wdata = clr_color_q;
      bus.ram_we    = 1'b1;
    end else if (do_pop) begin
      bus.ram_addr  = fifo_q[rd_ptr_q].addr;
      bus.ram_wdata = fifo_q[rd_ptr_q].color;
      bus.ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      last_addr_q  <= bus.ram_addr;
      last_wdata_q <= bus.ram_wdata;
      count_q      <= count_d;
      clr_done_q   <= 1'b0;

      if (push) begin
        fifo_q[wr_ptr_q] <= '{addr: pix_addr(bus.wr_y, bus.wr_x), color: bus.wr_color};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            clr_color_q <= clr_color_i;
            clr_busy_q  <= 1'b1;
            clr_cnt_q   <= '0;
            // A push accepted in the same cycle must be written before the fill.
            state_q     <= (count_d != '0) ? DRAIN : CLEAR;
          end
        end
        DRAIN: begin
          if (count_q == '0) begin
            clr_cnt_q <= '0;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          // Display slots simply stall the counter, so no address is skipped.
          if (do_clear) begin
            if (clr_cnt_q == LAST_ADDR) begin
              clr_cnt_q  <= '0;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              clr_cnt_q <= clr_cnt_q + 19'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter.
// Instance a uses the full 640x480 geometry for the address, FIFO and
// reset-abort cases.
// Instance b uses a 16x8 geometry, so a complete clear runs in a few hundred
// cycles. A small RAM model lets its contents be read back.
// Stimulus pushes the expected RAM writes into per-instance queues.
// A monitor pops and compares one entry on every ram_we.
module tb_vram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        clr_req_a, clr_req_b;
  logic [11:0] clr_color_a, clr_color_b;
  logic        clr_busy_a, clr_busy_b, clr_done_a, clr_done_b;
  logic [11:0] rdata_a;
  logic [11:0] mem_b [128];

  vram_arbiter_if bus_a ();
  vram_arbiter_if bus_b ();

  vram_arbiter u_a (
    .clk_i(clk), .rst_ni(rst_a_n), .bus(bus_a),
    .clr_req_i(clr_req_a), .clr_color_i(clr_color_a),
    .clr_busy_o(clr_busy_a), .clr_done_o(clr_done_a)
  );

  vram_arbiter #(.H_RES(16), .V_RES(8), .DEPTH(4)) u_b (
    .clk_i(clk), .rst_ni(rst_b_n), .bus(bus_b),
    .clr_req_i(clr_req_b), .clr_color_i(clr_color_b),
    .clr_busy_o(clr_busy_b), .clr_done_o(clr_done_b)
  );

  assign bus_a.ram_rdata = rdata_a;
  assign bus_b.ram_rdata = mem_b[bus_b.ram_addr[6:0]];

  always @(negedge clk) begin
    if (bus_b.ram_we) mem_b[bus_b.ram_addr[6:0]] <= bus_b.ram_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_a  = 0;
  int done_b  = 0;
  int viol_b  = 0;
  logic [30:0] exp_a [$];
  logic [30:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [30:0] e;
    forever begin
      @(negedge clk);
      if (clr_done_a) done_a++;
      if (clr_done_b) done_b++;
      if (clr_busy_b && bus_b.wr_ready) viol_b++;
      if (bus_a.ram_we) begin
        check("a_we_in_display", {31'b0, bus_a.read_pixel}, 32'd1);
        if (exp_a.size() == 0) check("a_unexpected_write", exp_a.size(), 32'd1);
        else begin
          e = exp_a.pop_front();
          check("a_write", {1'b0, bus_a.ram_addr, bus_a.ram_wdata}, {1'b0, e});
        end
      end
      if (bus_b.ram_we) begin
        check("b_we_in_display", {31'b0, bus_b.read_pixel}, 32'd1);
        if (exp_b.size() == 0) check("b_unexpected_write", exp_b.size(), 32'd1);
        else begin
          e = exp_b.pop_front();
          check("b_write", {1'b0, bus_b.ram_addr, bus_b.ram_wdata}, {1'b0, e});
        end
      end
    end
  endtask

  // Runs n clear writes on instance a, then asserts reset in the cycle
  // that would write address n.
  task automatic clear_abort(input int n, input logic [11:0] c);
    clr_req_a   = 1'b1;
    clr_color_a = c;
    for (int k = 0; k < n; k++) exp_a.push_back({19'(k), c});
    tick(1);
    clr_req_a = 1'b0;
    tick(n);
    rst_a_n = 1'b0;
    @(negedge clk);
    check("a_we_forced_in_rst", bus_a.ram_we, 0);
    tick(1);
    @(negedge clk);
    check("a_abort_busy", clr_busy_a, 0);
    check("a_abort_writes", exp_a.size(), 0);
    tick(2);
    rst_a_n = 1'b1;
    tick(3);
    @(negedge clk);
    check("a_no_done", done_a, 0);
    tick(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx [4] = '{0, 639, 5, 100};
    int ty [4] = '{0, 479, 1, 200};
    int ta [4] = '{0, 307199, 645, 128100};
    logic [11:0] tc [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
    int h, v;

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    clr_req_a = 1'b0; clr_req_b = 1'b0;
    clr_color_a = '0; clr_color_b = '0;
    rdata_a = '0;
    bus_a.read_pixel = 1'b1; bus_a.row = '0; bus_a.col = '0;
    bus_a.wr_valid = 1'b0; bus_a.wr_x = '0; bus_a.wr_y = '0; bus_a.wr_color = '0;
    bus_b.read_pixel = 1'b1; bus_b.row = '0; bus_b.col = '0;
    bus_b.wr_valid = 1'b0; bus_b.wr_x = '0; bus_b.wr_y = '0; bus_b.wr_color = '0;
    fork monitor(); join_none

    // Reset state
    tick(2);
    @(negedge clk);
    check("rst_ram_we", bus_a.ram_we, 0);
    check("rst_ram_addr", bus_a.ram_addr, 0);
    check("rst_ram_wdata", bus_a.ram_wdata, 0);
    check("rst_clr_busy", clr_busy_a, 0);
    check("rst_clr_done", clr_done_a, 0);
    tick(1);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick(1);
    @(negedge clk);
    check("ready_after_rst", bus_a.wr_ready, 1);
    tick(1);

    // Single write (10,2) -> 1290; display data pass-through
    bus_a.wr_valid = 1'b1; bus_a.wr_x = 10'd10; bus_a.wr_y = 9'd2; bus_a.wr_color = 12'hABC;
    exp_a.push_back({19'd1290, 12'hABC});
    rdata_a = 12'h5A5;
    @(negedge clk);
    check("t1_ready", bus_a.wr_ready, 1);
    tick(1);
    bus_a.wr_valid = 1'b0;
    @(negedge clk);
    check("vga_passthru", bus_a.vga_data, 12'h5A5);
    tick(1);

    // Display held at (479,639); four writes fill the FIFO
    bus_a.read_pixel = 1'b0; bus_a.row = 9'd479; bus_a.col = 10'd639;
    bus_a.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.wr_x = 10'(tx[i]); bus_a.wr_y = 9'(ty[i]); bus_a.wr_color = tc[i];
      exp_a.push_back({19'(ta[i]), tc[i]});
      @(negedge clk);
      check("disp_addr", bus_a.ram_addr, 307199);
      tick(1);
    end
    bus_a.wr_x = 10'd1; bus_a.wr_y = 9'd1; bus_a.wr_color = 12'hFFF;
    rdata_a = 12'h3C3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_ready", bus_a.wr_ready, 0);
      check("disp_addr_full", bus_a.ram_addr, 307199);
      check("vga_passthru2", bus_a.vga_data, 12'h3C3);
      tick(1);
    end
    bus_a.wr_valid = 1'b0;
    bus_a.read_pixel = 1'b1;
    tick(6);
    @(negedge clk);
    check("a_drain_empty", exp_a.size(), 0);
    tick(1);

    // Out-of-range writes are dropped; push+pop at count DEPTH-1
    bus_a.read_pixel = 1'b0;
    bus_a.wr_valid = 1'b1; bus_a.wr_x = 10'd640; bus_a.wr_y = 9'd0; bus_a.wr_color = 12'hEEE;
    @(negedge clk);
    check("oor_ready_x", bus_a.wr_ready, 1);
    tick(1);
    bus_a.wr_x = 10'd0; bus_a.wr_y = 9'd480; bus_a.wr_color = 12'hDDD;
    @(negedge clk);
    check("oor_ready_y", bus_a.wr_ready, 1);
    tick(1);
    for (int i = 1; i <= 3; i++) begin
      bus_a.wr_x = 10'(i); bus_a.wr_y = 9'd0; bus_a.wr_color = 12'hC00 + 12'(i);
      exp_a.push_back({19'(i), 12'hC00 + 12'(i)});
      tick(1);
    end
    bus_a.wr_x = 10'd4; bus_a.wr_y = 9'd0; bus_a.wr_color = 12'hC04;
    exp_a.push_back({19'd4, 12'hC04});
    bus_a.read_pixel = 1'b1;
    @(negedge clk);
    check("oor_not_stored", bus_a.wr_ready, 1);
    tick(1);
    bus_a.wr_valid = 1'b0;
    bus_a.read_pixel = 1'b0;
    @(negedge clk);
    check("pushpop_ready", bus_a.wr_ready, 1);
    tick(1);
    bus_a.read_pixel = 1'b1;
    tick(6);
    @(negedge clk);
    check("a_oor_drain_empty", exp_a.size(), 0);
    tick(1);

    // Small instance: clear with two pending writes under a blanking pattern
    bus_b.read_pixel = 1'b0;
    bus_b.wr_valid = 1'b1; bus_b.wr_x = 10'd3; bus_b.wr_y = 9'd1; bus_b.wr_color = 12'hA01;
    exp_b.push_back({19'd19, 12'hA01});
    tick(1);
    bus_b.wr_x = 10'd15; bus_b.wr_y = 9'd7; bus_b.wr_color = 12'hA02;
    exp_b.push_back({19'd127, 12'hA02});
    tick(1);
    bus_b.wr_valid = 1'b0;
    clr_req_b = 1'b1; clr_color_b = 12'h0F0;
    for (int k = 0; k < 128; k++) exp_b.push_back({19'(k), 12'h0F0});
    tick(1);
    clr_req_b = 1'b0; clr_color_b = 12'hF00;
    @(negedge clk);
    check("b_busy", clr_busy_b, 1);
    check("b_ready_busy", bus_b.wr_ready, 0);
    tick(1);
    for (int cyc = 0; cyc < 5000 && done_b == 0; cyc++) begin
      h = cyc % 25;
      v = (cyc / 25) % 21;
      bus_b.read_pixel = !((h < 20) && (v < 16));
      bus_b.row = 9'(v % 8);
      bus_b.col = 10'(h % 16);
      clr_req_b = (cyc == 300);
      clr_color_b = (cyc == 300) ? 12'hFFF : 12'hF00;
      tick(1);
    end
    clr_req_b = 1'b0;
    bus_b.read_pixel = 1'b1;
    @(negedge clk);
    check("b_done_seen", done_b, 1);
    check("b_all_written", exp_b.size(), 0);
    check("b_busy_off", clr_busy_b, 0);
    check("b_ready_in_busy", viol_b, 0);
    check("b_ready_idle", bus_b.wr_ready, 1);
    tick(3);
    @(negedge clk);
    check("b_done_once", done_b, 1);
    tick(1);
    bus_b.read_pixel = 1'b0; bus_b.row = 9'd7; bus_b.col = 10'd15;
    @(negedge clk);
    check("b_readback_127", bus_b.vga_data, 12'h0F0);
    tick(1);
    bus_b.row = 9'd1; bus_b.col = 10'd3;
    @(negedge clk);
    check("b_readback_19", bus_b.vga_data, 12'h0F0);
    tick(1);
    bus_b.read_pixel = 1'b1;

    // Reset at clear counter 1000, then a fresh clear restarts at 0
    clear_abort(1000, 12'h123);
    clear_abort(20, 12'h456);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
